// File: rtl/blinds_pkg.sv
// Shared types and constants for the blinds actuator.
// Optional feature macro: BLINDS_ENDSTOP_EN (adds the HOME state).
package blinds_pkg;

    typedef logic [1:0] blinds_cmd_t;

    localparam blinds_cmd_t BLINDS_OPEN       = 2'b00;
    localparam blinds_cmd_t BLINDS_THIRD      = 2'b01;
    localparam blinds_cmd_t BLINDS_TWO_THIRDS = 2'b10;
    localparam blinds_cmd_t BLINDS_CLOSED     = 2'b11;

    localparam logic DIR_OPEN  = 1'b0;
    localparam logic DIR_CLOSE = 1'b1;

`ifdef BLINDS_ENDSTOP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOME   = 2'd3
    } blinds_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } blinds_state_t;
`endif

endpackage

// File: rtl/blinds_actuator_if.sv
// Command handshake between the light-level block (master) and the actuator (slave).
interface blinds_actuator_if;
    import blinds_pkg::*;

    blinds_cmd_t cmd;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/blinds_step_timer.sv
// Motor step divider: pulses tick once every STEP_DIV cycles while run is high.
module blinds_step_timer #(
    parameter int STEP_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] count;

    assign tick = run && (count == DIV_W'(STEP_DIV - 1));

    // Divider counts 0..STEP_DIV-1 while running and clears whenever idle.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end
endmodule

// File: rtl/blinds_actuator.sv
// Blinds motor actuator: accepts a 2-bit level command, steps the motor to the
// matching position, settles, then pulses done.
// Optional feature macro: BLINDS_ENDSTOP_EN (endstop inputs, HOME state, fault).
module blinds_actuator
    import blinds_pkg::*;
#(
    parameter int STEPS_PER_LEVEL = 4,
    parameter int STEP_DIV        = 2,
    parameter int SETTLE_CYCLES   = 3,
    parameter int POS_W           = $clog2(3 * STEPS_PER_LEVEL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    blinds_actuator_if.slave cmd_if,
    output logic             motor_en,
    output logic             motor_dir,
    output logic             motor_step,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
`ifdef BLINDS_ENDSTOP_EN
    ,
    input  logic             top_stop,
    input  logic             bottom_stop,
    output logic             fault
`endif
);
    localparam logic [POS_W-1:0] MAX_POS = POS_W'(3 * STEPS_PER_LEVEL);
    localparam int               SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    blinds_state_t    state;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] cmd_target;
    logic [POS_W-1:0] pos_next;
    logic [SET_W-1:0] settle_cnt;
    logic             zero_pend;
    logic             step_run;
    logic             step_tick;

    assign cmd_if.cmd_ready = (state == ST_IDLE);
    assign busy             = (state != ST_IDLE);
    assign motor_step       = step_tick;

    assign cmd_target = POS_W'(32'(cmd_if.cmd) * STEPS_PER_LEVEL);

    // Next position one step along the current direction, saturating at both ends.
    assign pos_next = (motor_dir == DIR_CLOSE)
                    ? ((position == MAX_POS) ? position : position + POS_W'(1))
                    : ((position == '0)      ? position : position - POS_W'(1));

`ifdef BLINDS_ENDSTOP_EN
    assign step_run = (state == ST_MOVE) || (state == ST_HOME);
`else
    assign step_run = (state == ST_MOVE);
`endif

    blinds_step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (step_run),
        .tick (step_tick)
    );

    // Control FSM: accept, move step by step, settle, report completion.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // updates from the same pre-edge values, independent of statement order.
        if (rst) begin
`ifdef BLINDS_ENDSTOP_EN
            state     <= ST_HOME;
            fault     <= 1'b0;
`else
            state     <= ST_IDLE;
`endif
            position   <= '0;
            target     <= '0;
            settle_cnt <= '0;
            motor_en   <= 1'b0;
            motor_dir  <= DIR_OPEN;
            done       <= 1'b0;
            zero_pend  <= 1'b0;
        end else begin
            // A zero-distance command reports done one cycle after acceptance.
            done      <= zero_pend;
            zero_pend <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        target <= cmd_target;
`ifdef BLINDS_ENDSTOP_EN
                        fault  <= 1'b0;
`endif
                        if (cmd_target == position) begin
                            zero_pend <= 1'b1;
                        end else begin
                            state     <= ST_MOVE;
                            motor_en  <= 1'b1;
                            motor_dir <= (cmd_target > position) ? DIR_CLOSE : DIR_OPEN;
                        end
                    end
                end

                ST_MOVE: begin
`ifdef BLINDS_ENDSTOP_EN
                    if (motor_dir == DIR_CLOSE && bottom_stop) begin
                        position   <= MAX_POS;
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        fault      <= 1'b1;
                    end else if (motor_dir == DIR_OPEN && top_stop) begin
                        position   <= '0;
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        fault      <= 1'b1;
                    end else
`endif
                    if (step_tick) begin
                        position <= pos_next;
                        if (pos_next == target) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state     <= ST_IDLE;
                        motor_en  <= 1'b0;
                        motor_dir <= DIR_OPEN;
                        done      <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

`ifdef BLINDS_ENDSTOP_EN
                ST_HOME: begin
                    // Drive open until the open-side endstop defines position zero.
                    if (top_stop) begin
                        position  <= '0;
                        state     <= ST_IDLE;
                        motor_en  <= 1'b0;
                        motor_dir <= DIR_OPEN;
                    end else begin
                        motor_en  <= 1'b1;
                        motor_dir <= DIR_OPEN;
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
